// File: rtl/addsub_pkg.sv
// addsub16_seq shared types and constants.
// Saturation bounds are width-generic helpers.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DATA_W = 16;
  localparam int NIB    = DATA_W / 4;
  localparam int NIB_W  = $clog2(NIB);

  // Most positive signed value of width w.
  function automatic logic [63:0] sat_pos(
    input int w
  );
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value of width w.
  function automatic logic [63:0] sat_neg(
    input int w
  );
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub16_seq_if.sv
// Request/response bundle of the nibble-serial
// add/sub unit; slave side is the unit.
interface addsub16_seq_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             flag_z_o;
  logic             flag_v_o;
  logic             flag_n_o;

  modport master (
    output start_i, sub_i, a_i, b_i,
    input  ready_o, busy_o, done_o,
    input  result_o,
    input  flag_z_o, flag_v_o, flag_n_o
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i,
    output ready_o, busy_o, done_o,
    output result_o,
    output flag_z_o, flag_v_o, flag_n_o
  );
endinterface

// File: rtl/addsub16_seq_nibble_cla.sv
// 4-bit carry-lookahead slice with signed
// overflow of the top bit; purely combinational.
module nibble_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovfl
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead carries, no ripple chain.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  assign ovfl = ~(a[3] ^ b[3]) & (sum[3] ^ a[3]);

endmodule

// File: rtl/addsub16_seq.sv
// Nibble-serial add/sub: one CLA slice reused
// over WIDTH/4 cycles, carry held in a flop.
module addsub16_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SAT   = 1
) (
  input  logic clk,
  input  logic rst_n,
  addsub16_seq_if.slave bus
);
  localparam int NIBS = WIDTH / 4;
  localparam int CW =
    (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(NIBS - 1);
  localparam logic [WIDTH-1:0] SAT_P =
    WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N =
    WIDTH'(sat_neg(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    nib_q, nib_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;

  logic [CW+1:0] base;
  logic [3:0]    s_a, s_b, s_sum;
  logic          s_cout, s_ovf;

  assign base = {nib_q, 2'b00};
  assign s_a  = a_q[base +: 4];
  assign s_b  = b_q[base +: 4];

  nibble_cla u_cla (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout),
    .ovfl (s_ovf)
  );

  // Next state: capture, per-nibble step, finish.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    nib_d   = nib_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i ^ {WIDTH{bus.sub_i}};
          carry_d = bus.sub_i;
          nib_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[base +: 4] = s_sum;
        carry_d = s_cout;
        if (nib_q == LAST) begin
          ovf_d   = s_ovf;
          state_d = DONE;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      DONE: begin
        if ((SAT != 0) && ovf_q) begin
          res_d = a_q[WIDTH-1] ? SAT_N : SAT_P;
        end else begin
          res_d = acc_q;
        end
        z_d     = (res_d == '0);
        v_d     = ovf_q;
        n_d     = res_d[WIDTH-1];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      nib_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      nib_q   <= nib_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = res_q;
  assign bus.flag_z_o = z_q;
  assign bus.flag_v_o = v_q;
  assign bus.flag_n_o = n_q;

endmodule
